// File: rtl/ram_access_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_access_controller                                                      |
// | Sequences 256x32 RAM strobes for single writes and 1..2^LEN_W read bursts. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ram_access_controller #(
  parameter int LEN_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [7:0]       req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [LEN_W-1:0] req_len,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_last,
  output logic             busy,
  output logic [7:0]       mem_addr,
  output logic [31:0]      mem_din,
  output logic             mem_en,
  output logic             mem_rw,
  input  logic [31:0]      mem_dout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             last_q, last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = req_wr ? S_WR : S_RD;
      S_WR:   state_d = S_RESP;
      S_RD:   state_d = S_RESP;
      S_RESP: if (rsp_ready) state_d = last_q ? S_IDLE : S_RD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    mem_en    = (state_q == S_WR) || (state_q == S_RD);
    mem_rw    = (state_q == S_WR);
    rsp_valid = (state_q == S_RESP);
    mem_addr  = addr_q;
    mem_din   = wdata_q;
    rsp_rdata = rdata_q;
    rsp_last  = last_q;
  end

  // addr_q only moves on edges that start a WR/RD cycle, so mem_addr holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      last_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          cnt_d  = req_wr ? '0 : req_len;
          // Write data only latched for writes so mem_din keeps its last driven value.
          if (req_wr) wdata_d = req_wdata;
        end
      end
      S_WR: begin
        rdata_d = '0;
        last_d  = 1'b1;
      end
      S_RD: begin
        rdata_d = mem_dout;
        last_d  = (cnt_q == '0);
      end
      S_RESP: begin
        if (rsp_ready && !last_q) begin
          addr_d = addr_q + 8'd1;
          cnt_d  = cnt_q - LEN_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/ram_access_controller.md
# ram_access_controller

Sequential initiator that drives the 256x32 RAM port (`addr`, `Dinput`, `en`, `rw`, `Dout`) on behalf of a requester such as the CPU load/store stage. It accepts single-word writes and 1..4-word incrementing read bursts over a valid/ready request channel. It sequences the RAM enable and read/write strobes, then returns read data, or a write acknowledge, over a valid/ready response channel with backpressure. It sits between the datapath and the RAM and is the only block that drives the RAM's control inputs.

## Interface
Parameters:
- `LEN_W`, default 2: width of the burst-length field; a read burst is `req_len+1` words (1..4 at default).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request this cycle.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  8  start word address.
- `req_wdata`  in  32  write data; ignored for reads.
- `req_len`  in  LEN_W  read burst length minus 1; ignored for writes.
- `rsp_valid`  out  1  response word or write ack present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  32  read data; 0 for a write ack.
- `rsp_last`  out  1  final response of the transaction.
- `busy`  out  1  FSM not in IDLE.
- `mem_addr`  out  8  to RAM `addr`.
- `mem_din`  out  32  to RAM `Dinput`.
- `mem_en`  out  1  to RAM `en`.
- `mem_rw`  out  1  to RAM `rw`; 1 = write, 0 = read.
- `mem_dout`  in  32  from RAM `Dout`.

## Operation
- States: IDLE, WR, RD, RESP.
- IDLE
  - `req_ready`=1.
  - On a `req_valid && req_ready` edge: latch addr, wdata, len and wr. Go to WR if `req_wr`, else RD.
- WR
  - Drive `mem_en`=1, `mem_rw`=1, `mem_addr`=latched address, `mem_din`=latched data for exactly one cycle.
  - The RAM commits the write at the end of this cycle.
  - Go to RESP with `rsp_rdata`=0 and `rsp_last`=1.
- RD
  - Drive `mem_en`=1, `mem_rw`=0, `mem_addr`=current address for one cycle.
  - At the closing edge, register `mem_dout` into `rsp_rdata`, set `rsp_last` = (remaining count == 0), and go to RESP.
- RESP
  - `rsp_valid`=1. Hold `rsp_rdata`/`rsp_last` stable until `rsp_valid && rsp_ready`.
  - On that handshake:
    - If `rsp_last`: go to IDLE.
    - Else: address = address+1 (8-bit wrap, 255 -> 0), count = count-1, go to RD.
- `mem_en`=0 in IDLE and RESP. The RAM is never strobed while a response is stalled.
- `mem_rw` returns to 0 whenever `mem_en`=0. `mem_addr`/`mem_din` hold their last driven values.
- `req_ready`=0 in every state except IDLE. No request is accepted while a transaction is in progress, so there is no overlap.
- `busy` = (state != IDLE).

## Timing
- Reset (`rst_n`=0, asynchronous):
  - state=IDLE.
  - `mem_en`=0, `mem_rw`=0, `mem_addr`=0, `mem_din`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_last`=0, `busy`=0.
  - `req_ready`=1 from the first cycle after release.
- Request accepted at edge N:
  - WR or RD is active in cycle N+1.
  - `rsp_valid` is first high in cycle N+2.
  - Minimum write-ack latency and first-read-word latency are both 2 cycles.
- Burst words: each subsequent word's `rsp_valid` is high 2 cycles after the previous response handshake. A k-word burst with `rsp_ready` held at 1 completes in 2k+1 cycles from acceptance to the return to IDLE.
- `req_ready` is high again the cycle after the final response handshake. Back-to-back transactions are therefore separated by one IDLE cycle.
- Reset asserted mid-transaction:
  - Immediate abort; all outputs take their reset values asynchronously.
  - A write whose WR cycle is cut short may or may not be committed. Software must not rely on it.
- Burst address wrap: a burst at 0xFE with `req_len`=3 reads 0xFE, 0xFF, 0x00, 0x01.
- `rsp_ready` held low: RESP holds indefinitely with no RAM strobe and stable outputs.

## Test plan
- Reset then idle: `rst_n` pulsed low mid-simulation -> all outputs 0 except `req_ready`=1; `mem_en` stays 0 with no requests.
- Single write then read: write 0xDEADBEEF to 0x45, then a 1-word read of 0x45 -> `mem_en`/`mem_rw`=1/1 for exactly one cycle; write ack with `rsp_last`=1 and `rsp_rdata`=0; read response `rsp_rdata`=0xDEADBEEF, `rsp_last`=1, 2 cycles after acceptance.
- Burst across bank boundary: preload 0x3E..0x41 with 0x3E..0x41; read at 0x3E with `req_len`=3 -> four responses 0x3E, 0x3F, 0x40, 0x41, `rsp_last` only on the 4th, total 9 cycles.
- Address wrap: preload 0xFF=0x11 and 0x00=0x22; read at 0xFF with `req_len`=1 -> responses 0x11 then 0x22.
- Backpressure: 2-word read with `rsp_ready` low for 5 cycles on word 1 -> `rsp_rdata` stable, `mem_en`=0 throughout the stall, `req_ready`=0, second word follows correctly.
- Mid-burst reset: assert `rst_n` low during the RD of word 2 -> `rsp_valid`=0 and `mem_en`=0 immediately; after release, a new 1-word read of 0x10 returns the correct data.
